stage_instruction_fetch: RTL and testbench

// - First stage of the multi-cycle/pipelined RV32I core. On enable, fetches the instruction word at pc

---
 rtl/core_pkg.sv | 41 ++++
 rtl/instr_opcode_check.sv | 13 +
 rtl/stage_instruction_fetch.sv | 74 +++++++
 tb/tb_stage_instruction_fetch.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: data widths, RV32I major opcodes, and the opcode legality helper.
package core_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned OPCODE_W = 7;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LOAD     = 7'b0000011,
    OP_MISC_MEM = 7'b0001111,
    OP_OP_IMM   = 7'b0010011,
    OP_AUIPC    = 7'b0010111,
    OP_STORE    = 7'b0100011,
    OP_OP       = 7'b0110011,
    OP_LUI      = 7'b0110111,
    OP_BRANCH   = 7'b1100011,
    OP_JALR     = 7'b1100111,
    OP_JAL      = 7'b1101111,
    OP_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_READ  = 2'd1,
    IF_DONE  = 2'd2,
    IF_STUCK = 2'd3
  } if_state_e;

  // True when the major opcode belongs to the base RV32I set.
  function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] opcode);
    logic legal;
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_opcode_check.sv
// Combinational legality check of an instruction's major opcode field.
module instr_opcode_check
  import core_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output logic                legal_c
);

  always_comb begin
    legal_c = is_legal_opcode(opcode);
  end

endmodule

// File: rtl/stage_instruction_fetch.sv
// Instruction fetch stage: one-cycle synchronous memory read, opcode check, latched result.
module stage_instruction_fetch
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] mem_r_data,
  output logic            is_complete,
  output logic [XLEN-1:0] mem_addr,
  output logic [ILEN-1:0] instr_bits
);

  if_state_e       state_q, state_d;
  logic [ILEN-1:0] instr_d;
  logic            complete_d;
  logic            opcode_legal_c;

  assign mem_addr = pc;

  instr_opcode_check u_opcode_check (
    .opcode  (mem_r_data[OPCODE_W-1:0]),
    .legal_c (opcode_legal_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IF_IDLE;
      instr_bits  <= '0;
      is_complete <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_bits  <= instr_d;
      is_complete <= complete_d;
    end
  end

  // Read data is only consumed in READ, so X on the bus elsewhere cannot reach the outputs.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_bits;
    complete_d = is_complete;
    case (state_q)
      IF_IDLE: begin
        if (enable) begin
          state_d    = IF_READ;
          complete_d = 1'b0;
        end
      end
      IF_READ: begin
        instr_d = mem_r_data;
        if (opcode_legal_c) begin
          state_d    = IF_DONE;
          complete_d = 1'b1;
        end else begin
          state_d    = IF_STUCK;
          complete_d = 1'b0;
        end
      end
      IF_DONE: begin
        if (!enable) state_d = IF_IDLE;
      end
      IF_STUCK: begin
        complete_d = 1'b0;
      end
      default: begin
        state_d    = IF_IDLE;
        complete_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_stage_instruction_fetch.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural fetch model.
module tb_stage_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] pc;
  logic [31:0] mem_r_data;
  logic        is_complete;
  logic [31:0] mem_addr;
  logic [31:0] instr_bits;

  int unsigned n_vec;
  int unsigned n_err;

  // Behavioural model: where the stage is in its fetch, plus the visible results.
  bit          m_fetching;
  bit          m_holding;
  bit          m_dead;
  bit          m_complete;
  logic [31:0] m_instr;

  logic [6:0] legal_ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  stage_instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pc          (pc),
    .mem_r_data  (mem_r_data),
    .is_complete (is_complete),
    .mem_addr    (mem_addr),
    .instr_bits  (instr_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_legal(input logic [31:0] word);
    foreach (legal_ops[i]) if (word[6:0] == legal_ops[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_edge();
    if (reset) begin
      m_fetching = 0; m_holding = 0; m_dead = 0; m_complete = 0; m_instr = '0;
    end else if (m_dead) begin
      m_complete = 0;
    end else if (m_fetching) begin
      m_fetching = 0;
      m_instr    = mem_r_data;
      if (ref_legal(mem_r_data)) begin
        m_complete = 1; m_holding = 1;
      end else begin
        m_complete = 0; m_dead = 1;
      end
    end else if (m_holding) begin
      if (!enable) m_holding = 0;
    end else if (enable) begin
      m_fetching = 1; m_complete = 0;
    end
  endtask

  task automatic step_and_check(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".cmp"},   32'(is_complete), 32'(m_complete));
    check({tag, ".instr"}, instr_bits, m_instr);
    check({tag, ".addr"},  mem_addr, pc);
  endtask

  task automatic drive(input bit r, input bit en, input logic [31:0] a, input logic [31:0] d);
    reset = r; enable = en; pc = a; mem_r_data = d;
  endtask

  // Enable a fetch at pc, supply data in the latency cycle, then drop enable for a few cycles.
  task automatic fetch_seq(input string tag, input logic [31:0] a, input logic [31:0] d);
    drive(0, 1, a, 32'hX);
    step_and_check({tag, ".start"});
    check({tag, ".start_clr"}, 32'(is_complete), 32'd0);
    mem_r_data = d;
    step_and_check({tag, ".read"});
    enable = 0; mem_r_data = 32'hX;
    for (int i = 0; i < 3; i++) step_and_check({tag, ".hold"});
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_fetching = 0; m_holding = 0; m_dead = 0; m_complete = 0; m_instr = '0;

    // 1: reset with enable low
    drive(1, 0, 32'hCAFEBABE, 32'h0);
    step_and_check("rst");
    step_and_check("rst");
    check("rst.cmp_const",   32'(is_complete), 32'd0);
    check("rst.instr_const", instr_bits, 32'h0);
    reset = 0;
    step_and_check("idle");

    // 2: ADDI fetch
    fetch_seq("addi", 32'hDEADBEEF, 32'hFFF78793);
    check("addi.final", instr_bits, 32'hFFF78793);
    check("addi.done",  32'(is_complete), 32'd1);

    // 3: LW fetch, completion drops at the start edge
    fetch_seq("lw", 32'hCAFED00D, 32'h00072603);
    check("lw.final", instr_bits, 32'h00072603);

    // 4: all-zero word is illegal and sticks
    drive(0, 1, 32'hDEADBEEF, 32'h0);
    step_and_check("stk.start");
    step_and_check("stk.read");
    for (int i = 0; i < 3; i++) step_and_check("stk.en1");
    enable = 0;
    for (int i = 0; i < 3; i++) step_and_check("stk.en0");
    enable = 1; mem_r_data = 32'h00000013;
    for (int i = 0; i < 3; i++) step_and_check("stk.retry");
    check("stk.const", 32'(is_complete), 32'd0);

    // 5: reset out of STUCK, then repeat the ADDI fetch
    drive(1, 0, 32'hDEADBEEF, 32'h0);
    step_and_check("rst2");
    reset = 0;
    fetch_seq("addi2", 32'hDEADBEEF, 32'hFFF78793);
    check("addi2.final", instr_bits, 32'hFFF78793);

    // 6: reset in the latency cycle
    drive(0, 1, 32'h00001000, 32'hX);
    step_and_check("rmid.start");
    drive(1, 1, 32'h00001000, 32'h00000033);
    step_and_check("rmid.rst");
    check("rmid.instr0", instr_bits, 32'h0);
    drive(0, 0, 32'h00001000, 32'h0);
    step_and_check("rmid.idle");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 9) < 8) d[6:0] = legal_ops[$urandom_range(0, 10)];
      drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), $urandom, d);
      step_and_check("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
